// File: rtl/pkt_bridge.sv
// Packet bridge from a push-only producer to a valid/ready consumer through a first-word-fall-through FIFO.
// Optional per-entry even parity is enabled by defining PKT_BRIDGE_PARITY_EN.
module pkt_bridge #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
`ifdef PKT_BRIDGE_PARITY_EN
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       out_par_err,
    output logic                       par_err_seen
`else
    output logic [CNT_W-1:0]           drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

    logic isFull;
    logic doPop;
    logic doPush;
    logic doDrop;

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rdPtr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = dropCnt_q;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign isFull = (count_q == FULL_CNT);
    assign doPop  = out_valid && out_ready;
    assign doPush = in_valid && (!isFull || doPop);
    assign doDrop = in_valid && isFull && !doPop;

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        if (doDrop) begin
            overflow_d = 1'b1;
            if (dropCnt_q != '1) begin
                dropCnt_d = dropCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Storage is not cleared by reset; reset only blocks a write in its own cycle.
    always_ff @(posedge clk) begin
        if (rst_n && doPush) begin
            mem_q[wrPtr_q] <= in_data;
        end
    end

`ifdef PKT_BRIDGE_PARITY_EN
    logic [DEPTH-1:0] parMem_q;
    logic             parErrSeen_q, parErrSeen_d;

    assign out_par_err  = out_valid && ((^mem_q[rdPtr_q]) != parMem_q[rdPtr_q]);
    assign par_err_seen = parErrSeen_q;

    always_comb begin
        parErrSeen_d = parErrSeen_q;
        if (doPop && out_par_err) begin
            parErrSeen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && doPush) begin
            parMem_q[wrPtr_q] <= ^in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parErrSeen_q <= 1'b0;
        end else begin
            parErrSeen_q <= parErrSeen_d;
        end
    end
`endif

endmodule
